// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, interrupts, mret and wfi at commit,
// drives the CSR trap/mret strobes and sequences pipeline flush and sleep.
package rei_pkg;
    localparam int XLEN = 32;
endpackage

module trap_ctrl #(
    parameter int XLEN         = rei_pkg::XLEN,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            exc_req_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_req_i,
    input  logic            wfi_req_i,
    input  logic            irq_ext_i,
    input  logic            irq_soft_i,
    input  logic            irq_timer_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic            mstatus_mie_i,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_tval_o,
    output logic            mret_o,
    output logic            flush_o,
    output logic            wfi_stall_o,
    output logic [XLEN-1:0] mip_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WFI   = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] IRQ_BIT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] CAUSE_MSI = IRQ_BIT | XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_MTI = IRQ_BIT | XLEN'(7);
    localparam logic [XLEN-1:0] CAUSE_MEI = IRQ_BIT | XLEN'(11);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    // Synchronizer bit order: {ext, soft, timer}
    logic [2:0]      irq_meta_q, irq_meta_d;
    logic [2:0]      irq_sync_q, irq_sync_d;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] en;
    logic            irq_pending;
    logic            irq_take;
    logic            issue_ok;

    always_comb begin
        irq_meta_d = {irq_ext_i, irq_soft_i, irq_timer_i};
        irq_sync_d = irq_meta_q;
    end

    always_comb begin
        mip     = '0;
        mip[11] = irq_sync_q[2];
        mip[3]  = irq_sync_q[1];
        mip[7]  = irq_sync_q[0];
    end

    assign en          = mip & mie_i;
    assign irq_pending = |en;
    assign irq_take    = irq_pending & mstatus_mie_i;
    assign issue_ok    = (state_q == ST_RUN) && !stall_i && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            irq_meta_q <= 3'd0;
            irq_sync_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_meta_q <= irq_meta_d;
            irq_sync_q <= irq_sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!stall_i) begin
                    if (exc_req_i || irq_take || mret_req_i) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 4'(FLUSH_CYCLES);
                    end else if (wfi_req_i) begin
                        state_d = ST_WFI;
                    end
                end
            end
            ST_FLUSH: begin
                // Counts down through stalls; the last flush cycle is cnt_q == 1.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WFI: begin
                if (irq_pending) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        trap_valid_o = 1'b0;
        trap_cause_o = '0;
        trap_tval_o  = '0;
        mret_o       = 1'b0;
        if (issue_ok) begin
            if (exc_req_i) begin
                trap_valid_o = 1'b1;
                trap_cause_o = exc_cause_i;
                trap_tval_o  = exc_tval_i;
            end else if (irq_take) begin
                trap_valid_o = 1'b1;
                if (en[11]) begin
                    trap_cause_o = CAUSE_MEI;
                end else if (en[3]) begin
                    trap_cause_o = CAUSE_MSI;
                end else begin
                    trap_cause_o = CAUSE_MTI;
                end
            end else if (mret_req_i) begin
                mret_o = 1'b1;
            end
        end
        flush_o     = (state_q == ST_FLUSH) && !rst_i;
        wfi_stall_o = (state_q == ST_WFI) && !rst_i;
        mip_o       = mip;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs change just after the falling edge,
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_trap_ctrl;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            stall_i;
    logic            exc_req_i;
    logic [XLEN-1:0] exc_cause_i;
    logic [XLEN-1:0] exc_tval_i;
    logic            mret_req_i;
    logic            wfi_req_i;
    logic            irq_ext_i;
    logic            irq_soft_i;
    logic            irq_timer_i;
    logic [XLEN-1:0] mie_i;
    logic            mstatus_mie_i;
    logic            trap_valid_o;
    logic [XLEN-1:0] trap_cause_o;
    logic [XLEN-1:0] trap_tval_o;
    logic            mret_o;
    logic            flush_o;
    logic            wfi_stall_o;
    logic [XLEN-1:0] mip_o;
    logic [1:0]      dbg_state_o;

    int n_pass  = 0;
    int n_total = 0;

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .exc_req_i     (exc_req_i),
        .exc_cause_i   (exc_cause_i),
        .exc_tval_i    (exc_tval_i),
        .mret_req_i    (mret_req_i),
        .wfi_req_i     (wfi_req_i),
        .irq_ext_i     (irq_ext_i),
        .irq_soft_i    (irq_soft_i),
        .irq_timer_i   (irq_timer_i),
        .mie_i         (mie_i),
        .mstatus_mie_i (mstatus_mie_i),
        .trap_valid_o  (trap_valid_o),
        .trap_cause_o  (trap_cause_o),
        .trap_tval_o   (trap_tval_o),
        .mret_o        (mret_o),
        .flush_o       (flush_o),
        .wfi_stall_o   (wfi_stall_o),
        .mip_o         (mip_o),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; exc_req_i = 1'b0; exc_cause_i = '0; exc_tval_i = '0;
        mret_req_i = 1'b0; wfi_req_i = 1'b0; irq_ext_i = 1'b0; irq_soft_i = 1'b0;
        irq_timer_i = 1'b0; mie_i = '0; mstatus_mie_i = 1'b0;

        // reset: outputs held at 0 even with a request present
        #2;
        exc_req_i = 1'b1; exc_cause_i = 32'd2; exc_tval_i = 32'hDEAD;
        #1;
        chk("rst_trap_valid", 32'(trap_valid_o), 0);
        chk("rst_trap_cause", trap_cause_o, 0);
        chk("rst_trap_tval", trap_tval_o, 0);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_wfi", 32'(wfi_stall_o), 0);
        chk("rst_mret", 32'(mret_o), 0);
        chk("rst_mip", mip_o, 0);
        chk("rst_state", 32'(dbg_state_o), 0);

        // exception right after reset release; held request is ignored in FLUSH
        tick(); rst_i = 1'b0; #1;
        chk("exc_valid", 32'(trap_valid_o), 1);
        chk("exc_cause", trap_cause_o, 32'd2);
        chk("exc_tval", trap_tval_o, 32'hDEAD);
        chk("exc_flush_issue", 32'(flush_o), 0);
        tick(); #1;
        chk("exc_flush1", 32'(flush_o), 1);
        chk("exc_ignored_in_flush", 32'(trap_valid_o), 0);
        chk("flush_cause_zero", trap_cause_o, 0);
        tick(); exc_req_i = 1'b0; #1;
        chk("exc_flush2", 32'(flush_o), 1);
        tick(); #1;
        chk("exc_flush_done", 32'(flush_o), 0);
        chk("exc_run_idle", 32'(trap_valid_o), 0);

        // ext + timer rise together: MEI taken two edges later
        mie_i = 32'h880; mstatus_mie_i = 1'b1; irq_ext_i = 1'b1; irq_timer_i = 1'b1; #1;
        chk("irq_sync0_mip", mip_o, 0);
        chk("irq_sync0_trap", 32'(trap_valid_o), 0);
        tick(); #1;
        chk("irq_sync1_mip", mip_o, 0);
        chk("irq_sync1_trap", 32'(trap_valid_o), 0);
        tick(); #1;
        chk("irq_mip", mip_o, 32'h880);
        chk("irq_valid", 32'(trap_valid_o), 1);
        chk("irq_cause_mei", trap_cause_o, 32'h8000000B);
        chk("irq_tval", trap_tval_o, 0);
        tick(); mstatus_mie_i = 1'b0; #1;
        chk("irq_flush1", 32'(flush_o), 1);
        tick(); #1;
        chk("irq_flush2", 32'(flush_o), 1);
        tick(); #1;
        chk("mstatus_gated", 32'(trap_valid_o), 0);
        chk("mstatus_gated_flush", 32'(flush_o), 0);
        tick(); mstatus_mie_i = 1'b1; mie_i = '0; #1;
        chk("mie_gated", 32'(trap_valid_o), 0);
        irq_ext_i = 1'b0; irq_timer_i = 1'b0;
        tick(); tick(); #1;
        chk("irq_cleared_mip", mip_o, 0);

        // MSI outranks MTI
        irq_soft_i = 1'b1; irq_timer_i = 1'b1;
        tick(); tick(); mie_i = 32'h88; #1;
        chk("msi_mip", mip_o, 32'h88);
        chk("msi_valid", 32'(trap_valid_o), 1);
        chk("msi_cause", trap_cause_o, 32'h80000003);
        tick(); mie_i = '0; irq_soft_i = 1'b0; irq_timer_i = 1'b0; #1;
        chk("msi_flush", 32'(flush_o), 1);
        tick(); tick(); #1;
        chk("msi_done_flush", 32'(flush_o), 0);
        chk("msi_done_mip", mip_o, 0);

        // exception beats a taken interrupt; interrupt follows the flush
        irq_timer_i = 1'b1;
        tick(); tick();
        mie_i = 32'h80; exc_req_i = 1'b1; exc_cause_i = 32'd5; exc_tval_i = 32'h44; #1;
        chk("both_cause_exc", trap_cause_o, 32'd5);
        chk("both_tval_exc", trap_tval_o, 32'h44);
        tick(); exc_req_i = 1'b0; #1;
        chk("both_flush1_valid", 32'(trap_valid_o), 0);
        chk("both_flush1", 32'(flush_o), 1);
        tick(); #1;
        chk("both_flush2_valid", 32'(trap_valid_o), 0);
        tick(); #1;
        chk("deferred_irq_valid", 32'(trap_valid_o), 1);
        chk("deferred_irq_cause", trap_cause_o, 32'h80000007);
        tick(); mie_i = '0; irq_timer_i = 1'b0; #1;
        chk("deferred_flush", 32'(flush_o), 1);
        tick(); tick(); #1;
        chk("deferred_done", 32'(flush_o), 0);

        // wfi with MIE clear: sleep, ignore exc/mret, wake 3 edges after irq_soft
        mstatus_mie_i = 1'b0; mie_i = 32'h8; wfi_req_i = 1'b1; #1;
        chk("wfi_issue_stall", 32'(wfi_stall_o), 0);
        tick(); wfi_req_i = 1'b0; exc_req_i = 1'b1; mret_req_i = 1'b1; #1;
        chk("wfi_stall", 32'(wfi_stall_o), 1);
        chk("wfi_exc_ignored", 32'(trap_valid_o), 0);
        chk("wfi_mret_ignored", 32'(mret_o), 0);
        tick(); exc_req_i = 1'b0; mret_req_i = 1'b0; irq_soft_i = 1'b1; #1;
        chk("wfi_e0", 32'(wfi_stall_o), 1);
        tick(); #1;
        chk("wfi_e1", 32'(wfi_stall_o), 1);
        tick(); #1;
        chk("wfi_e2", 32'(wfi_stall_o), 1);
        chk("wfi_e2_mip", mip_o, 32'h8);
        tick(); #1;
        chk("wfi_e3_wake", 32'(wfi_stall_o), 0);
        chk("wfi_no_trap", 32'(trap_valid_o), 0);
        irq_soft_i = 1'b0; mie_i = '0;
        tick(); tick();

        // mret held through 3 stalled cycles
        mret_req_i = 1'b1; stall_i = 1'b1; #1;
        chk("mret_stall0", 32'(mret_o), 0);
        chk("mret_stall0_flush", 32'(flush_o), 0);
        tick(); #1;
        chk("mret_stall1", 32'(mret_o), 0);
        tick(); #1;
        chk("mret_stall2", 32'(mret_o), 0);
        tick(); stall_i = 1'b0; #1;
        chk("mret_pulse", 32'(mret_o), 1);
        chk("mret_no_trap", 32'(trap_valid_o), 0);
        tick(); mret_req_i = 1'b0; #1;
        chk("mret_once", 32'(mret_o), 0);
        chk("mret_flush1", 32'(flush_o), 1);
        tick(); #1;
        chk("mret_flush2", 32'(flush_o), 1);
        tick(); #1;
        chk("mret_flush_done", 32'(flush_o), 0);

        // stalled exception waits
        stall_i = 1'b1; exc_req_i = 1'b1; exc_cause_i = 32'd7; exc_tval_i = 32'h1; #1;
        chk("stall_no_trap", 32'(trap_valid_o), 0);
        tick(); #1;
        chk("stall_no_flush", 32'(flush_o), 0);

        // async reset mid-FLUSH, then immediate trap after release
        stall_i = 1'b0; #1;
        chk("unstall_trap", 32'(trap_valid_o), 1);
        tick(); exc_req_i = 1'b0; #1;
        chk("pre_rst_flush", 32'(flush_o), 1);
        #2 rst_i = 1'b1; #1;
        chk("rst_mid_flush", 32'(flush_o), 0);
        chk("rst_mid_flush_state", 32'(dbg_state_o), 0);
        tick(); rst_i = 1'b0; exc_req_i = 1'b1; exc_cause_i = 32'd9; exc_tval_i = 32'h12; #1;
        chk("post_rst_valid", 32'(trap_valid_o), 1);
        chk("post_rst_cause", trap_cause_o, 32'd9);
        tick(); exc_req_i = 1'b0; #1;
        chk("post_rst_flush", 32'(flush_o), 1);
        tick(); tick();

        // async reset mid-WFI
        wfi_req_i = 1'b1;
        tick(); wfi_req_i = 1'b0; #1;
        chk("pre_rst_wfi", 32'(wfi_stall_o), 1);
        #2 rst_i = 1'b1; #1;
        chk("rst_mid_wfi", 32'(wfi_stall_o), 0);
        tick(); rst_i = 1'b0; #1;
        chk("post_rst_wfi", 32'(wfi_stall_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter XLEN, default rei_pkg::XLEN (32): data width of cause, tval and mip.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles flush_o stays asserted after a trap or mret, range 1..15.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 stall_i  in  1  pipeline stall; no event is issued while high.
REQ-006 exc_req_i  in  1  synchronous exception from the commit stage.
REQ-007 exc_cause_i  in  XLEN  exception cause code.
REQ-008 exc_tval_i  in  XLEN  exception tval.
REQ-009 mret_req_i  in  1  mret at the commit stage.
REQ-010 wfi_req_i  in  1  wfi at the commit stage.
REQ-011 irq_ext_i, irq_soft_i, irq_timer_i  in  1 each  level interrupt lines, asynchronous to clk_i.
REQ-012 mie_i  in  XLEN  current mie register value.
REQ-013 mstatus_mie_i  in  1  current mstatus.MIE.
REQ-014 trap_valid_o  out  1  one-cycle trap strobe to the CSR register file exc.valid.
REQ-015 trap_cause_o  out  XLEN  trap cause, valid with trap_valid_o.
REQ-016 trap_tval_o  out  XLEN  trap tval, valid with trap_valid_o.
REQ-017 mret_o  out  1  one-cycle strobe to the CSR register file mret input.
REQ-018 flush_o  out  1  pipeline flush request.
REQ-019 wfi_stall_o  out  1  hold the front end while sleeping.
REQ-020 mip_o  out  XLEN  synchronized pending bits: MSIP bit 3, MTIP bit 7, MEIP bit 11; all other bits 0.

Function
REQ-021 Each irq line SHALL pass through a 2-flop synchronizer; mip_o is the second flop, so a line change is visible in mip_o 2 edges later.
REQ-022 The FSM SHALL have three states: RUN, FLUSH, WFI.
REQ-023 Enabled pending set: en = mip_o & mie_i. The interrupt is taken when en != 0 and mstatus_mie_i = 1.
REQ-024 In RUN with stall_i=0, exactly one event SHALL issue per cycle, in this priority: exc_req_i > taken interrupt > mret_req_i > wfi_req_i.
REQ-025 Interrupt priority SHALL be MEI (cause 0x8000000B) > MSI (0x80000003) > MTI (0x80000007), with trap_tval_o = 0.
REQ-026 On an exception, trap_cause_o = exc_cause_i and trap_tval_o = exc_tval_i.
REQ-027 trap_valid_o, trap_cause_o and trap_tval_o SHALL be combinational in the issuing cycle; cause and tval are 0 when trap_valid_o = 0.
REQ-028 A trap or mret SHALL move the FSM RUN -> FLUSH and load the counter with FLUSH_CYCLES.
REQ-029 In FLUSH: flush_o = 1, the counter decrements each cycle regardless of stall_i, and the FSM returns to RUN after FLUSH_CYCLES cycles. All requests arriving in FLUSH are ignored.
REQ-030 A wfi with no taken interrupt SHALL move RUN -> WFI; wfi_stall_o = 1 while in WFI.
REQ-031 WFI SHALL exit to RUN in the cycle after en != 0, regardless of mstatus_mie_i. If the interrupt is globally enabled, it is taken in RUN on the next non-stalled cycle.
REQ-032 In WFI, exc_req_i and mret_req_i SHALL be ignored.
REQ-033 With stall_i = 1 in RUN, there SHALL be no strobes and no state change.
REQ-034 If mie_i or mstatus_mie_i drops, a pending interrupt SHALL not be taken, and is not remembered.

Reset
REQ-035 While rst_i = 1, asynchronously: FSM = RUN, counter = 0, synchronizer flops = 0.
REQ-036 While rst_i = 1, all outputs SHALL be 0; this includes a reset arriving mid-FLUSH or mid-WFI.
REQ-037 After rst_i deasserts, the first event can issue on the first clock edge.

Verification
REQ-038 exc_req_i = 1, cause 2, tval 0xDEAD, stall_i = 0 -> same cycle: trap_valid_o = 1, cause 2, tval 0xDEAD; flush_o = 1 for exactly FLUSH_CYCLES = 2 cycles; then RUN.
REQ-039 irq_ext_i and irq_timer_i rise together, mie_i = 0x880, mstatus_mie_i = 1 -> trap 2 edges later with cause 0x8000000B and tval 0.
REQ-040 exc_req_i and a taken interrupt in the same cycle -> only the exception trap issues; the interrupt is taken after FLUSH if it is still pending.
REQ-041 wfi_req_i with mstatus_mie_i = 0 -> wfi_stall_o = 1; raise irq_soft_i with mie_i[3] = 1 -> wfi_stall_o falls 3 edges later, and no trap issues.
REQ-042 mret_req_i with stall_i = 1 for 3 cycles, then 0 -> mret_o pulses once, only in the first unstalled cycle, then flush_o.
REQ-043 rst_i asserted mid-FLUSH, asynchronous to clk_i -> flush_o drops immediately; after release, an exc_req_i issues a trap on the next edge.
